// File: rtl/countdown_timer_arbiter_if.sv
// Bundle between timeout requesters and the shared countdown timer.
// The abort signal exists only when COUNTDOWN_ARB_ABORT_EN is defined.
interface countdown_timer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] load_val;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [WIDTH-1:0]         count;
  logic [NUM_REQ-1:0]       done;
`ifdef COUNTDOWN_ARB_ABORT_EN
  logic                     abort;
`endif

  modport master (
    output req, load_val,
`ifdef COUNTDOWN_ARB_ABORT_EN
    output abort,
`endif
    input  grant, busy, count, done
  );

  modport slave (
    input  req, load_val,
`ifdef COUNTDOWN_ARB_ABORT_EN
    input  abort,
`endif
    output grant, busy, count, done
  );
endinterface

// File: rtl/countdown_timer_arbiter.sv
// One down counter shared round-robin among NUM_REQ timeout requesters.
// Optional abort input enabled by defining COUNTDOWN_ARB_ABORT_EN.
module countdown_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                    clock0,
  input  logic                    reset,
  countdown_timer_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     win;
  logic                 found;
  logic                 abort_req;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] o);
    if (int'(o) == NUM_REQ - 1) return '0;
    else return o + 1'b1;
  endfunction

`ifdef COUNTDOWN_ARB_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Round-robin search upward from the pointer, first requester wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [PTR_W-1:0] cand;
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE, DONE: begin
        if (found) begin
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          count_d = bus.load_val[int'(win)*WIDTH +: WIDTH];
          owner_d = win;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Abort outranks expiry so an aborted run never reports done
        if (abort_req) begin
          grant_d = '0;
          ptr_d   = next_ptr(owner_q);
          state_d = IDLE;
        end else if (count_q == '0) begin
          done_d[owner_q] = 1'b1;
          grant_d         = '0;
          ptr_d           = next_ptr(owner_q);
          state_d         = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '1;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
endmodule

// File: tb/tb_countdown_timer_arbiter.sv
// Scoreboard bench for countdown_timer_arbiter: a deadline-based model predicts
// grant/done events, and a monitor checks them plus the per-cycle outputs.
module tb_countdown_timer_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort_drv = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) intf ();
`ifdef COUNTDOWN_ARB_ABORT_EN
  assign intf.abort = abort_drv;
`endif

  countdown_timer_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock0(clk),
    .reset (rst),
    .bus   (intf.slave)
  );

  typedef struct {
    int          is_done;
    int          idx;
    logic [W-1:0] cnt;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an owner with an absolute deadline (grant cycle + L + 1)
  int           cyc = 0;
  int           mowner = -1;
  int           mptr = 0;
  int           mdeadline = 0;
  logic [W-1:0] mcount = '1;
  logic [N-1:0] mdone = '0;

  always @(posedge clk) begin
    logic ab;
    cyc++;
    mdone = '0;
`ifdef COUNTDOWN_ARB_ABORT_EN
    ab = abort_drv;
`else
    ab = 1'b0;
`endif
    if (rst) begin
      mowner = -1;
      mptr   = 0;
      mcount = '1;
    end else if (mowner >= 0) begin
      if (ab) begin
        mptr   = (mowner + 1) % N;
        mowner = -1;
      end else if (cyc == mdeadline) begin
        mdone = N'(1) << mowner;
        exp_q.push_back('{1, mowner, '0, cyc});
        mptr   = (mowner + 1) % N;
        mowner = -1;
      end else begin
        mcount = mcount - 1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (mowner < 0 && intf.req[i]) begin
          mowner    = i;
          mcount    = intf.load_val[i*W +: W];
          mdeadline = cyc + int'(mcount) + 1;
          exp_q.push_back('{0, i, mcount, cyc});
        end
      end
    end
  end

  // Monitor: pops an expected event whenever the DUT shows a grant or done
  logic [N-1:0] prev_grant = '0;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (intf.done !== '0 || (intf.grant !== '0 && prev_grant === '0)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {intf.grant, intf.done}, '0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.is_done != 0) begin
            chk("done_vec", intf.done, N'(1) << e.idx);
          end else begin
            chk("grant_vec", intf.grant, N'(1) << e.idx);
            chk("grant_count", intf.count, e.cnt);
          end
          chk("event_cycle", cyc, e.cyc);
        end
      end
      chk("cycle_outputs", {intf.grant, intf.busy, intf.count, intf.done},
          {(mowner >= 0) ? (N'(1) << mowner) : N'(0), (mowner >= 0), mcount, mdone});
    end
    prev_grant = intf.grant;
  end

  task automatic wait_count(input logic [W-1:0] v, input int budget);
    int n = 0;
    while (!(intf.busy === 1'b1 && intf.count === v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_count_timeout", (n < budget), 1'b1);
  endtask

  task automatic request(input int idx, input logic [W-1:0] l);
    intf.load_val[idx*W +: W] = l;
    intf.req = N'(1) << idx;
    @(negedge clk);
    intf.req = '0;
  endtask

  initial begin
    intf.req      = '0;
    intf.load_val = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_grant", intf.grant, '0);
    chk("reset_done", intf.done, '0);
    chk("reset_busy", intf.busy, 1'b0);
    chk("reset_count", intf.count, 16'hffff);
    rst = 1'b0;

    // Single request, L=5
    request(0, 16'd5);
    repeat (8) @(negedge clk);

    // Round-robin from pointer 0, all loads 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) intf.load_val[i*W +: W] = 16'd2;
    intf.req = '1;
    repeat (22) @(negedge clk);
    intf.req = '0;
    repeat (5) @(negedge clk);

    // Zero load
    request(2, 16'd0);
    repeat (3) @(negedge clk);

    // Mid-run reset at count 3, then a fresh grant
    intf.load_val[1*W +: W] = 16'd9;
    intf.req = 4'b0010;
    @(negedge clk);
    intf.req = '0;
    wait_count(16'd3, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_done", intf.done, '0);
    chk("midreset_count", intf.count, 16'hffff);
    repeat (3) @(negedge clk);
    request(3, 16'd4);
    repeat (7) @(negedge clk);

`ifdef COUNTDOWN_ARB_ABORT_EN
    request(0, 16'd12);
    wait_count(16'd7, 20);
    abort_drv = 1'b1;
    @(negedge clk);
    abort_drv = 1'b0;
    chk("abort_grant", intf.grant, '0);
    chk("abort_count", intf.count, 16'd7);
    chk("abort_busy", intf.busy, 1'b0);
    repeat (3) @(negedge clk);
    request(1, 16'd3);
    wait_count(16'd0, 10);
    abort_drv = 1'b1;
    @(negedge clk);
    abort_drv = 1'b0;
    chk("abort_zero_done", intf.done, '0);
    repeat (3) @(negedge clk);
`endif

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      intf.req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) intf.load_val[i*W +: W] = W'($urandom_range(0, 6));
`ifdef COUNTDOWN_ARB_ABORT_EN
      abort_drv = ($urandom_range(0, 15) == 0);
`endif
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    intf.req = '0;
    abort_drv = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Full-scale load, no wrap below zero
    request(1, 16'hffff);
    repeat (65540) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
